// File: rtl/branch_outcome_tracker_if.sv
// Prediction/resolution/training bundle between the predictor, the back end and the tracker.
interface branch_outcome_tracker_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic             pred_valid;
    logic             pred_taken;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic             update_req;
    logic             update_taken;
    logic             mispredict;
    logic             err_orphan;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] total_cnt;
    logic [CNT_W-1:0] miss_cnt;

    // Producer of predictions/resolutions, consumer of training and statistics.
    modport master (
        output pred_valid, pred_taken, res_valid, res_taken,
        input  pred_ready, update_req, update_taken, mispredict, err_orphan,
               occupancy, total_cnt, miss_cnt
    );

    // The tracker itself.
    modport slave (
        input  pred_valid, pred_taken, res_valid, res_taken,
        output pred_ready, update_req, update_taken, mispredict, err_orphan,
               occupancy, total_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_outcome_tracker.sv
// In-order queue of issued branch predictions, matched against resolved outcomes to
// train the predictor, flag mispredictions, flush on a miss and count hits/misses.
module branch_outcome_tracker #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    branch_outcome_tracker_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             upd_req_q, upd_req_d;
    logic             upd_taken_q, upd_taken_d;
    logic             mis_q, mis_d;
    logic             orphan_q, orphan_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] miss_q, miss_d;

    logic empty_c, full_c, resolve_c, miss_c, push_c;

    assign empty_c   = (occ_q == '0);
    assign full_c    = (occ_q == OCC_W'(DEPTH));
    assign resolve_c = bus.res_valid && !empty_c;
    assign miss_c    = resolve_c && (mem_q[rd_ptr_q] != bus.res_taken);
    // A mispredict flushes everything, including a prediction arriving alongside it.
    assign push_c    = bus.pred_valid && !full_c && !miss_c;

    // Next-state for queue, training pulses and saturating statistics.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        upd_req_d   = 1'b0;
        upd_taken_d = upd_taken_q;
        mis_d       = 1'b0;
        orphan_d    = 1'b0;
        total_d     = total_q;
        miss_d      = miss_q;

        if (push_c) begin
            mem_d[wr_ptr_q] = bus.pred_taken;
        end

        if (miss_c) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
            rd_ptr_d = rd_ptr_q + PTR_W'(resolve_c);
            occ_d    = occ_q + OCC_W'(push_c) - OCC_W'(resolve_c);
        end

        if (resolve_c) begin
            upd_req_d   = 1'b1;
            upd_taken_d = bus.res_taken;
            mis_d       = miss_c;
            if (total_q != CNT_MAX) total_d = total_q + CNT_W'(1);
            if (miss_c && (miss_q != CNT_MAX)) miss_d = miss_q + CNT_W'(1);
        end else if (bus.res_valid) begin
            orphan_d = 1'b1;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            upd_req_q   <= 1'b0;
            upd_taken_q <= 1'b0;
            mis_q       <= 1'b0;
            orphan_q    <= 1'b0;
            total_q     <= '0;
            miss_q      <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            upd_req_q   <= upd_req_d;
            upd_taken_q <= upd_taken_d;
            mis_q       <= mis_d;
            orphan_q    <= orphan_d;
            total_q     <= total_d;
            miss_q      <= miss_d;
        end
    end

    assign bus.pred_ready   = !full_c;
    assign bus.update_req   = upd_req_q;
    assign bus.update_taken = upd_taken_q;
    assign bus.mispredict   = mis_q;
    assign bus.err_orphan   = orphan_q;
    assign bus.occupancy    = occ_q;
    assign bus.total_cnt    = total_q;
    assign bus.miss_cnt     = miss_q;
endmodule

// File: tb/tb_branch_outcome_tracker.sv
// Bench for branch_outcome_tracker: directed vector table, hand sequences for reset and
// counter saturation, and randomized traffic against a queue-based reference model.
module tb_branch_outcome_tracker;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_outcome_tracker_if #(.DEPTH(DEPTH), .CNT_W(16)) bus ();
    branch_outcome_tracker_if #(.DEPTH(DEPTH), .CNT_W(3))  sbus ();

    branch_outcome_tracker #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    branch_outcome_tracker #(.DEPTH(DEPTH), .CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .bus(sbus)
    );

    typedef struct {
        bit pv, pt, rv, rt;
        bit rdy;
        bit req, ut, mis, orph;
        int occ, tot, mcnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit pv, input bit pt, input bit rv, input bit rt);
        bus.pred_valid = pv;
        bus.pred_taken = pt;
        bus.res_valid  = rv;
        bus.res_taken  = rt;
    endtask

    task automatic check_outs(input string tag, input bit req, input bit ut, input bit mis,
                              input bit orph, input int occ, input int tot, input int mcnt);
        chk({tag, ".update_req"},   int'(bus.update_req),   int'(req));
        chk({tag, ".update_taken"}, int'(bus.update_taken), int'(ut));
        chk({tag, ".mispredict"},   int'(bus.mispredict),   int'(mis));
        chk({tag, ".err_orphan"},   int'(bus.err_orphan),   int'(orph));
        chk({tag, ".occupancy"},    int'(bus.occupancy),    occ);
        chk({tag, ".total_cnt"},    int'(bus.total_cnt),    tot);
        chk({tag, ".miss_cnt"},     int'(bus.miss_cnt),     mcnt);
    endtask

    function automatic vec_t mk(bit pv, bit pt, bit rv, bit rt, bit rdy,
                                bit req, bit ut, bit mis, bit orph, int occ, int tot, int mcnt);
        vec_t v;
        v.pv = pv; v.pt = pt; v.rv = rv; v.rt = rt; v.rdy = rdy;
        v.req = req; v.ut = ut; v.mis = mis; v.orph = orph;
        v.occ = occ; v.tot = tot; v.mcnt = mcnt;
        return v;
    endfunction

    // Reference model state: the queue of outstanding predictions plus plain counters.
    bit m_q[$];
    int m_tot, m_miss;
    bit m_ut;

    initial begin
        int max16;
        max16 = 65535;
        drive(0, 0, 0, 0);
        sbus.pred_valid = 0; sbus.pred_taken = 0; sbus.res_valid = 0; sbus.res_taken = 0;

        //           pv pt rv rt rdy req ut mis orph occ tot miss
        // in-order hits
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 0, 0, 2, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 2, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 3, 0));
        // mispredict flush drops the same-cycle push
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 3, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 2, 3, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 3, 3, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 4, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 4, 1));
        // fill, overflow ignored, resolve while full, pointer wrap
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 1, 4, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 2, 4, 1));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 3, 4, 1));
        vecs.push_back(mk(1, 1, 0, 0, 1, 0, 1, 0, 0, 4, 4, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 4, 4, 1));
        vecs.push_back(mk(1, 0, 1, 1, 0, 1, 1, 0, 0, 3, 5, 1));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 4, 5, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 3, 6, 1));
        vecs.push_back(mk(1, 1, 1, 1, 1, 1, 1, 0, 0, 3, 7, 1));
        vecs.push_back(mk(1, 0, 1, 1, 1, 1, 1, 0, 0, 3, 8, 1));
        vecs.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 0, 3, 9, 1));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 0, 0, 2, 10, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 11, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 12, 1));
        // orphan resolution with a same-cycle push, then a hit on that push
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 12, 1));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 13, 1));

        // reset state
        tick();
        reset = 1'b0;
        chk("reset.pred_ready", int'(bus.pred_ready), 1);
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].pv, vecs[i].pt, vecs[i].rv, vecs[i].rt);
            chk({tag, ".pred_ready"}, int'(bus.pred_ready), int'(vecs[i].rdy));
            tick();
            check_outs(tag, vecs[i].req, vecs[i].ut, vecs[i].mis, vecs[i].orph,
                       vecs[i].occ, vecs[i].tot, vecs[i].mcnt);
        end
        drive(0, 0, 0, 0);

        // steady push + correct resolve at occupancy 2, then reset mid-stream
        reset = 1'b1; tick(); reset = 1'b0;
        drive(1, 1, 0, 0); tick(); tick();
        chk("steady.occ_start", int'(bus.occupancy), 2);
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 1, 1);
            tick();
            chk("steady.occupancy", int'(bus.occupancy), 2);
            chk("steady.update_req", int'(bus.update_req), 1);
        end
        chk("steady.total_cnt", int'(bus.total_cnt), 10);
        chk("steady.miss_cnt", int'(bus.miss_cnt), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0);
        chk("midreset.pred_ready", int'(bus.pred_ready), 1);
        check_outs("midreset", 0, 0, 0, 0, 0, 0, 0);

        // randomized traffic against the reference model
        m_q.delete(); m_tot = 0; m_miss = 0; m_ut = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit pv, pt, rv, rt, e_req, e_mis, e_orph, miss, h;
            int start_sz;
            pv = 1'($urandom_range(0, 99) < 60);
            pt = 1'($urandom);
            rv = 1'($urandom_range(0, 99) < 45);
            rt = 1'($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0;
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0) rt = m_q[0];
            drive(pv, pt, rv, rt);
            start_sz = m_q.size();
            chk("rand.pred_ready", int'(bus.pred_ready), int'(start_sz != DEPTH));
            e_req = 0; e_mis = 0; e_orph = 0; miss = 0;
            if (rv && start_sz > 0) begin
                h = m_q.pop_front();
                miss = (h != rt);
                e_req = 1; e_mis = miss; m_ut = rt;
                if (m_tot < max16) m_tot++;
                if (miss && m_miss < max16) m_miss++;
                if (miss) m_q.delete();
            end else if (rv) begin
                e_orph = 1;
            end
            if (pv && start_sz < DEPTH && !miss) m_q.push_back(pt);
            tick();
            check_outs("rand", e_req, m_ut, e_mis, e_orph, m_q.size(), m_tot, m_miss);
        end
        drive(0, 0, 0, 0);

        // narrow counters saturate instead of wrapping
        for (int i = 0; i < 9; i++) begin
            sbus.pred_valid = 1; sbus.pred_taken = 0; sbus.res_valid = 0; sbus.res_taken = 0;
            tick();
            sbus.pred_valid = 0; sbus.res_valid = 1; sbus.res_taken = 1;
            tick();
            chk("sat.mispredict", int'(sbus.mispredict), 1);
        end
        sbus.res_valid = 0;
        chk("sat.total_cnt", int'(sbus.total_cnt), 7);
        chk("sat.miss_cnt", int'(sbus.miss_cnt), 7);
        chk("sat.occupancy", int'(sbus.occupancy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
